// File: rtl/addr_wr_en_responder.sv
// Responder end of the addr/wr/en interface: register array with
// immediate writes, fixed-latency reads, range errors and counters.
module addr_wr_en_responder #(
  parameter int AW     = 6,
  parameter int DW     = 8,
  parameter int DEPTH  = 48,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          err,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [3:0]  LAT_M1  = 4'(RD_LAT - 1);

  state_t        state;
  state_t        state_d;
  logic [3:0]    cnt;
  logic [3:0]    cnt_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] raddr;
  logic          rok;
  logic          in_rng;
  logic          wr_hit;
  logic          wr_bad;
  logic          rd_acc;
  logic          rd_done;

  assign in_rng = {1'b0, addr} < DEPTH_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ready   = 1'b0;
    wr_hit  = 1'b0;
    wr_bad  = 1'b0;
    rd_acc  = 1'b0;
    rd_done = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (en && wr) begin
          wr_hit = in_rng;
          wr_bad = !in_rng;
        end else if (en) begin
          rd_acc  = 1'b1;
          state_d = RD_WAIT;
          cnt_d   = LAT_M1;
        end
      end
      RD_WAIT: begin
        if (cnt == 4'd0) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // No write can land while a read waits, so sampling the array at
  // completion equals sampling it at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      raddr  <= '0;
      rok    <= 1'b0;
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      rvalid <= rd_done;
      err    <= wr_bad | (rd_done & !rok);
      if (wr_hit) begin
        mem[addr] <= wdata;
        wr_cnt    <= wr_cnt + 16'd1;
      end
      if (rd_acc) begin
        raddr <= addr;
        rok   <= in_rng;
      end
      if (rd_done) begin
        rdata <= rok ? mem[raddr] : '0;
        if (rok) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/addr_wr_en_responder.md
Name: addr_wr_en_responder

Overview:
- Responder (target) end of the single-clock addr/wr/en stimulus interface driven by the team's benches.
- Holds a DEPTH x DW register array and accepts one request per `clk` edge while `ready` is high.
- Writes complete immediately; reads return data after a fixed, parameterised latency with a one-cycle `rvalid` pulse.
- Flags out-of-range addresses and keeps read/write transaction counters for bench scoreboarding.

Parameters:
- AW, 6, address width.
- DW, 8, data width.
- DEPTH, 48, number of implemented locations (1..2**AW); addresses >= DEPTH are out of range.
- RD_LAT, 2, read latency in cycles from acceptance edge to `rvalid` (legal 1..15).

Ports:
- clk  in  1  clock, 25 MHz nominal, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  request strobe.
- wr  in  1  1 = write, 0 = read; sampled with `en`.
- addr  in  AW  location.
- wdata  in  DW  write data; sampled with `en` and `wr`.
- ready  out  1  responder can accept a request this cycle.
- rdata  out  DW  read data; valid only while `rvalid` = 1.
- rvalid  out  1  one-cycle read-data strobe.
- err  out  1  one-cycle out-of-range strobe.
- wr_cnt  out  16  accepted in-range writes, wraps at 2**16.
- rd_cnt  out  16  completed in-range reads, wraps at 2**16.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Outputs: `ready` = 1, `rvalid` = 0, `err` = 0, `rdata` = 0, `wr_cnt` = 0, `rd_cnt` = 0.
  - All array locations cleared to 0.
  - Deassertion is taken synchronously; the first acceptance is possible at the first posedge after deassertion.
- Acceptance: a request is accepted at a posedge where `en` = 1 and `ready` = 1. `en` while `ready` = 0 is ignored with no side effects.
- FSM states: IDLE and RD_WAIT.
- IDLE, accepted write (wr = 1):
  - In range: mem[addr] <= wdata at that edge and `wr_cnt` increments. State stays IDLE and `ready` stays 1, so back-to-back writes run every cycle.
  - Out of range: memory unchanged, `wr_cnt` unchanged, `err` = 1 for the following cycle.
- IDLE, accepted read (wr = 0):
  - Latch the address and whether it is in range.
  - Load the latency counter with RD_LAT-1, go to RD_WAIT, drive `ready` = 0.
- RD_WAIT:
  - Counter decrements each cycle.
  - At the edge where the counter is 0: `rvalid` = 1 and `rdata` = mem[latched addr] (or 0 if out of range) for exactly one cycle. In the same cycle, `err` = 1 if out of range; otherwise `rd_cnt` increments.
  - State returns to IDLE with `ready` = 1 in the same cycle as `rvalid`.
  - A request present during the `rvalid` cycle is accepted at the next edge.
- Latency: `rvalid` is high in the cycle starting RD_LAT edges after the acceptance edge. With RD_LAT = 1 it is the cycle immediately after acceptance.
- Read data reflects array contents at the acceptance edge. A write cannot occur during RD_WAIT because `ready` = 0.
- `rdata` holds its last value when `rvalid` = 0. `err` and `rvalid` are never high for more than one consecutive cycle per request.
- Counter wrap: 16'hFFFF + 1 -> 16'h0000, with no flag.
- Reset mid-read: pending read is discarded, no `rvalid`, `ready` = 1 immediately.
- `wr`, `addr` and `wdata` are don't-care when `en` = 0 or `ready` = 0.

Test Plan:
- Reset, then write 8'hA5 to addr 6'd3 and read addr 6'd3 (RD_LAT = 2) -> `ready` low 2 cycles, `rvalid` pulse with `rdata` = 8'hA5, `wr_cnt` = 1, `rd_cnt` = 1.
- Writes on 6 consecutive cycles to addrs 0..5 with data 8'h10..8'h15, then sequential reads -> `ready` stays 1 through all writes; reads return 8'h10..8'h15 in order, each spaced RD_LAT+... cycles apart; `wr_cnt` = 6.
- Write to addr 6'd50 (>= DEPTH 48), then read 6'd50 -> write: `err` one cycle, memory and `wr_cnt` unchanged. Read: `rvalid` with `rdata` = 0 and `err` in the same cycle; `rd_cnt` unchanged.
- Assert `en` with wr = 1 to addr 6'd7 while a read is pending (`ready` = 0) -> write ignored; a subsequent read of 6'd7 returns 0.
- Pull `rst_n` low one cycle after a read is accepted -> no `rvalid`, `ready` = 1, counters 0, previously written location reads 0.
- Randomised addr/wr/en on posedge for 1000 cycles against a reference model -> every `rdata` matches; `wr_cnt` and `rd_cnt` equal the model counts.
